multicycle_ctrl: RTL and testbench

Main sequencing FSM for the multi-cycle MIPS-subset datapath (PC, unified memory, IR, MDR, A/B, ALUOut, register bank, Ula32).
- Decodes opcode/funct taken from the IR outputs.
- Drives every datapath select and write-enable once per state.
- Resolves conditional PC writes internally from the ALU zero flag, so the top level has no PCWrite feedback logic.
- Absorbs a parameterised memory read latency.

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle MIPS-subset datapath.
// Moore decode from state and wait counter; branch PC write qualified by alu_zero.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mdr_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [2:0]         alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPE   = 4'd6,
    S_WB_R    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI    = 4'd9,
    S_WB_I    = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] LAST   = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last;

  assign last      = (cnt_q == LAST);
  assign state_dbg = STATE_W'(state_q);

  // State and wait-counter registers, aborted to fetch by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore outputs; everything forced low while in reset
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = OP_ADD;
          cnt_d     = cnt_q + 3'd1;
          if (last) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            cnt_d    = '0;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = OP_ADD;
          case (opcode)
            6'h00: begin
              if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24)
                state_d = S_RTYPE;
              else if (funct == 6'h08)
                state_d = S_JR;
              else
                state_d = S_ILLEGAL;
            end
            6'h23, 6'h2B: state_d = S_MEMADDR;
            6'h04, 6'h05: state_d = S_BRANCH;
            6'h08:        state_d = S_ADDI;
            6'h02:        state_d = S_JUMP;
            default:      state_d = S_ILLEGAL;
          endcase
        end
        S_MEMADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = OP_ADD;
          state_d   = (opcode == 6'h2B) ? S_MEMWR :
                      (opcode == 6'h23) ? S_MEMRD : S_FETCH;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
          cnt_d    = cnt_q + 3'd1;
          if (last) begin
            mdr_write = 1'b1;
            cnt_d     = '0;
            state_d   = S_WB_MEM;
          end
        end
        S_WB_MEM: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_RTYPE: begin
          alu_src_a = 1'b1;
          alu_op    = (funct == 6'h22) ? OP_SUB :
                      (funct == 6'h24) ? OP_AND : OP_ADD;
          state_d   = S_WB_R;
        end
        S_WB_R: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = OP_SUB;
          pc_source  = 2'b01;
          instr_done = 1'b1;
          pc_write   = (opcode == 6'h05) ? ~alu_zero : alu_zero;
          state_d    = S_FETCH;
        end
        S_ADDI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = OP_ADD;
          state_d   = S_WB_I;
        end
        S_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_JR: begin
          pc_source  = 2'b11;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_ILLEGAL: begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: two instances (MEM_WAIT 1 and 2)
// run random instruction streams against a per-instruction sequence model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] st;
  } ov_t;

  localparam int NI = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [5:0] opc [2];
  logic [5:0] fnc [2];
  logic       az  [2];
  logic       done [2];
  ov_t        ov  [2];
  ov_t        q   [2][$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input ov_t act, input ov_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ov_t blank(input int st);
    ov_t e;
    e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic ov_t fetch_item(input int c, input int mw);
    ov_t e;
    e = blank(0);
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    e.alu_op    = 3'b001;
    if (c == mw) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end
    return e;
  endfunction

  // Expected per-cycle outputs of one whole instruction
  task automatic build(input int k, input int mw, input logic [5:0] op,
                       input logic [5:0] fn, input logic z);
    ov_t e;
    for (int c = 0; c <= mw; c++) q[k].push_back(fetch_item(c, mw));
    e = blank(1); e.alu_src_b = 2'b11; e.alu_op = 3'b001;
    q[k].push_back(e);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      e = blank(6); e.alu_src_a = 1'b1;
      e.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      q[k].push_back(e);
      e = blank(7); e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
      q[k].push_back(e);
    end else if (op == 6'h00 && fn == 6'h08) begin
      e = blank(12); e.pc_source = 2'b11; e.pc_write = 1'b1; e.instr_done = 1'b1;
      q[k].push_back(e);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = blank(2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b001;
      q[k].push_back(e);
      if (op == 6'h23) begin
        for (int c = 0; c <= mw; c++) begin
          e = blank(3); e.iord = 1'b1; e.mem_read = 1'b1;
          e.mdr_write = (c == mw);
          q[k].push_back(e);
        end
        e = blank(4); e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        q[k].push_back(e);
      end else begin
        e = blank(5); e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = 1'b1;
        q[k].push_back(e);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e = blank(8); e.alu_src_a = 1'b1; e.alu_op = 3'b010;
      e.pc_source = 2'b01; e.instr_done = 1'b1;
      e.pc_write = (op == 6'h04) ? z : !z;
      q[k].push_back(e);
    end else if (op == 6'h08) begin
      e = blank(9); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b001;
      q[k].push_back(e);
      e = blank(10); e.reg_write = 1'b1; e.instr_done = 1'b1;
      q[k].push_back(e);
    end else if (op == 6'h02) begin
      e = blank(11); e.pc_source = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1;
      q[k].push_back(e);
    end else begin
      e = blank(13); e.illegal_op = 1'b1; e.instr_done = 1'b1;
      q[k].push_back(e);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int MW = k + 1;
    logic       pw, io, mr, mwr, irw, mdw, rw, m2r, rd, asa, idn, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic [3:0] sd;

    multicycle_ctrl #(.MEM_WAIT(MW), .STATE_W(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opc[k]),
      .funct      (fnc[k]),
      .alu_zero   (az[k]),
      .pc_write   (pw),
      .iord       (io),
      .mem_read   (mr),
      .mem_write  (mwr),
      .ir_write   (irw),
      .mdr_write  (mdw),
      .reg_write  (rw),
      .mem_to_reg (m2r),
      .reg_dst    (rd),
      .alu_src_a  (asa),
      .alu_src_b  (asb),
      .pc_source  (pcs),
      .alu_op     (aop),
      .instr_done (idn),
      .illegal_op (ill),
      .state_dbg  (sd)
    );

    assign ov[k] = {pw, io, mr, mwr, irw, mdw, rw, m2r, rd, asa,
                    asb, pcs, aop, idn, ill, sd};

    // Monitor: one expected item per cycle while a sequence is pending
    always @(negedge clk) begin
      ov_t e;
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        chk($sformatf("seq_mw%0d", MW), ov[k], e);
      end
    end

    // Driver: directed instructions first, then random ones
    initial begin
      logic [5:0] op, fn;
      logic       z;
      logic [5:0] ops [10];
      logic [5:0] fns [5];
      int         t;
      done[k] = 1'b0;
      ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
              6'h08, 6'h02, 6'h3F, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h00};
      wait (go);
      for (int i = 0; i < NI; i++) begin
        fn = 6'h00;
        z  = 1'b0;
        case (i)
          0: begin op = 6'h00; fn = 6'h20; end
          1: op = 6'h23;
          2: begin op = 6'h04; z = 1'b1; end
          3: begin op = 6'h05; z = 1'b1; end
          4: op = 6'h3F;
          5: begin op = 6'h00; fn = 6'h08; end
          default: begin
            ops[9] = 6'($urandom);
            fns[4] = 6'($urandom);
            op = ops[$urandom_range(0, 9)];
            fn = fns[$urandom_range(0, 4)];
            z  = 1'($urandom);
          end
        endcase
        opc[k] = op;
        fnc[k] = fn;
        az[k]  = z;
        build(k, MW, op, fn, z);
        t = 0;
        while (q[k].size() > 0 && t < 100) begin
          @(negedge clk);
          #1;
          t++;
        end
        if (q[k].size() > 0) begin
          checks++;
          errors++;
          $display("FAIL drain_mw%0d: %0d items left, required 0", MW, q[k].size());
          q[k].delete();
        end
      end
      done[k] = 1'b1;
    end
  end

  initial begin
    ov_t e;
    int  t;
    reset = 1'b1;
    go    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      opc[k] = 6'h00;
      fnc[k] = 6'h20;
      az[k]  = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("reset_zero_mw1", ov[0], '0);
      chk("reset_zero_mw2", ov[1], '0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    go    = 1'b1;

    t = 0;
    while (!(done[0] && done[1]) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL drivers_done: got %0b%0b required 11", done[0], done[1]);
    end

    // Asynchronous reset in the middle of a load's memory wait
    opc[0] = 6'h23;
    opc[1] = 6'h23;
    t = 0;
    while (ov[1].st != 4'd3 && t < 60) begin
      @(negedge clk);
      t++;
    end
    e = blank(3); e.iord = 1'b1; e.mem_read = 1'b1;
    chk("memrd_reached", ov[1], e);
    #2;
    reset = 1'b1;
    #1;
    chk("async_zero_mw1", ov[0], '0);
    chk("async_zero_mw2", ov[1], '0);
    repeat (2) begin
      @(negedge clk);
      chk("held_zero_mw2", ov[1], '0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("restart_c0_mw1", ov[0], fetch_item(0, 1));
    chk("restart_c0_mw2", ov[1], fetch_item(0, 2));
    @(negedge clk);
    chk("restart_c1_mw1", ov[0], fetch_item(1, 1));
    chk("restart_c1_mw2", ov[1], fetch_item(1, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
